// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - CPU data-SRAM responder with byte-lane writes, registered read data and optional wait states
// One access commits per request; with WAIT_CYCLES > 0 the request is latched and held in BUSY while stallreq is high.
module data_sram_resp #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        acc_err
);

  localparam int         DEPTH    = 2**ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         req_wen_q, req_wen_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [31:0]        req_wdata_q, req_wdata_d;
  logic [31:0]        rdata_q;
  logic               acc_err_q;

  logic               commit;
  logic               stall;
  logic [3:0]         c_wen;
  logic [31:0]        c_addr;
  logic [31:0]        c_wdata;
  logic [ADDR_W-1:0]  widx;
  logic               in_range;
  logic               unused_addr_lsb;

  logic [31:0]        mem [DEPTH];

  assign widx            = c_addr[ADDR_W+1:2];
  assign in_range        = (c_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign unused_addr_lsb = ^c_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    commit      = 1'b0;
    stall       = 1'b0;
    c_wen       = data_sram_wen;
    c_addr      = data_sram_addr;
    c_wdata     = data_sram_wdata;
    if (WAIT_CYCLES == 0) begin
      commit = data_sram_en;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_sram_en) begin
            req_wen_d   = data_sram_wen;
            req_addr_d  = data_sram_addr;
            req_wdata_d = data_sram_wdata;
            cnt_d       = CNT_INIT;
            state_d     = BUSY;
            stall       = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
          end else begin
            // Commit from the latched copy; live inputs are ignored while busy.
            commit  = 1'b1;
            c_wen   = req_wen_q;
            c_addr  = req_addr_q;
            c_wdata = req_wdata_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_wen_q   <= 4'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      acc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      acc_err_q   <= commit & ~in_range;
      if (commit && (c_wen == 4'd0)) begin
        rdata_q <= in_range ? mem[widx] : 32'd0;
      end
    end
  end

  // RAM contents survive reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wen[i]) begin
          mem[widx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign acc_err         = acc_err_q;
  assign stallreq        = stall & ~rst;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench for data_sram_resp at WAIT_CYCLES 0, 2 and 3
// Three instances share clk/rst; a word-array model predicts rdata, acc_err and the stall window per access.
module tb_data_sram_resp;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          AW   = 10;

  logic        clk;
  logic        rst;
  logic        en      [3];
  logic [3:0]  wen     [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata   [3];
  logic        stallreq[3];
  logic        acc_err [3];

  int n_checks;
  int n_fail;

  logic [31:0] mdl    [3][1024];
  logic [31:0] exp_rd [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_resp #(
      .ADDR_W      (AW),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .BASE_ADDR   (BASE)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en[g]),
      .data_sram_wen   (wen[g]),
      .data_sram_addr  (addr[g]),
      .data_sram_wdata (wdata[g]),
      .data_sram_rdata (rdata[g]),
      .stallreq        (stallreq[g]),
      .acc_err         (acc_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic bit in_rng(logic [31:0] a);
    return (a >> (AW + 2)) == (BASE >> (AW + 2));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on instance k; entry and exit are 1 time unit after a posedge.
  task automatic access(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d, bit gap);
    int          nw;
    int          wi;
    logic [31:0] word;
    nw = wc(k);
    wi = int'(a[AW+1:2]);
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    for (int c = 0; c <= nw; c++) begin
      #1;
      chk("stallreq", {31'd0, stallreq[k]}, (c < nw) ? 32'd1 : 32'd0);
      tick();
      if (c < nw) begin
        en[k] = 1'($urandom); wen[k] = 4'($urandom);
        addr[k] = $urandom; wdata[k] = $urandom;
      end
    end
    en[k] = 1'b0; wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
    if (in_rng(a)) begin
      if (w != 4'd0) begin
        word = mdl[k][wi];
        for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
        mdl[k][wi] = word;
      end else begin
        exp_rd[k] = mdl[k][wi];
      end
    end else if (w == 4'd0) begin
      exp_rd[k] = 32'd0;
    end
    chk("rdata", rdata[k], exp_rd[k]);
    chk("acc_err", {31'd0, acc_err[k]}, in_rng(a) ? 32'd0 : 32'd1);
    if (gap) begin
      tick();
      chk("acc_err_pulse", {31'd0, acc_err[k]}, 32'd0);
      chk("rdata_hold", rdata[k], exp_rd[k]);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return {20'($urandom_range(1, 1048575)), 10'($urandom_range(0, 31)), 2'($urandom)};
    return {20'd0, 10'($urandom_range(0, 31)), 2'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0; exp_rd[k] = 32'd0;
    end
    en[2] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_acc_err", {31'd0, acc_err[k]}, 32'd0);
      chk("rst_stallreq", {31'd0, stallreq[k]}, 32'd0);
    end
    en[2] = 1'b0;
    rst = 1'b0;
    tick();

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++)
        access(k, 4'hF, 32'(i * 4), $urandom, 1'b0);

    // Write then read 0x40 back to back, zero wait.
    access(0, 4'hF, 32'h40, 32'hDEADBEEF, 1'b0);
    access(0, 4'h0, 32'h40, 32'd0, 1'b1);
    chk("t1_rdata", rdata[0], 32'hDEADBEEF);

    // Single-lane write leaves other lanes intact.
    for (int k = 0; k < 3; k++) begin
      access(k, 4'hF, 32'h44, 32'h11223344, 1'b0);
      access(k, 4'b0100, 32'h44, 32'hAAAAAAAA, 1'b0);
      access(k, 4'h0, 32'h44, 32'd0, 1'b1);
      chk("t2_merge", rdata[k], 32'h11AA3344);
    end

    // W=3 read with inputs scrambled during BUSY.
    access(2, 4'h0, 32'h40, 32'd0, 1'b1);

    // Out of range write and read; word 0 must be untouched.
    for (int k = 0; k < 3; k++) begin
      access(k, 4'hF, BASE + 32'd4096, $urandom, 1'b1);
      access(k, 4'h0, BASE + 32'd4096, 32'd0, 1'b1);
      chk("t4_oor_rdata", rdata[k], 32'd0);
      access(k, 4'h0, 32'h0, 32'd0, 1'b1);
    end

    // Reset during BUSY drops the pending write on the W=2 instance.
    en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h40; wdata[1] = 32'h5;
    tick();
    rst = 1'b1; en[1] = 1'b0; wen[1] = 4'd0;
    #1;
    chk("t5_stall_in_rst", {31'd0, stallreq[1]}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'd0;
    #1;
    chk("t5_stall", {31'd0, stallreq[1]}, 32'd0);
    chk("t5_rdata", rdata[1], 32'd0);
    tick();
    access(1, 4'h0, 32'h40, 32'd0, 1'b1);

    // Write/read of the same word in consecutive accepted cycles.
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      access(k, 4'hF, 32'h60, d, 1'b0);
      access(k, 4'h0, 32'h60, 32'd0, 1'b1);
      chk("t6_fwd", rdata[k], d);
    end

    for (int n = 0; n < 40; n++)
      for (int k = 0; k < 3; k++)
        access(k, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom), rand_addr(), $urandom,
               1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
